// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the writeback stage: load funct3 encodings
// and the writeback sequencing states.
package rv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    ECALL_WAIT = 2'd1,
    HALTED     = 2'd2
  } wb_state_t;

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: selects the byte/half lane of a raw data word,
// sign- or zero-extends it, and flags misaligned halfword/word accesses.
module load_align
  import rv_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o,
  output logic        misalign_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // NOTE: every output is given a default first so no path leaves it unassigned (no latch).
  always_comb begin
    byte_v     = word_i[7:0];
    half_v     = offset_i[1] ? word_i[31:16] : word_i[15:0];
    data_o     = word_i;
    misalign_o = 1'b0;

    case (offset_i)
      2'd1:    byte_v = word_i[15:8];
      2'd2:    byte_v = word_i[23:16];
      2'd3:    byte_v = word_i[31:24];
      default: byte_v = word_i[7:0];
    endcase

    case (funct3_i)
      F3_LB:  data_o = {{24{byte_v[7]}}, byte_v};
      F3_LBU: data_o = {24'h0, byte_v};
      F3_LH: begin
        data_o     = {{16{half_v[15]}}, half_v};
        misalign_o = offset_i[0];
      end
      F3_LHU: begin
        data_o     = {16'h0, half_v};
        misalign_o = offset_i[0];
      end
      // LW and the undefined encodings all behave as a full-word load.
      default: begin
        data_o     = word_i;
        misalign_o = (offset_i != 2'b00);
      end
    endcase

    if (misalign_o) data_o = 32'h0;
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback stage: drives the register-file write
// port, sequences ecall retirement against halt_in and counts retirements.
module wb_stage
  import rv_pkg::*;
#(
  parameter int          CNT_W    = 64,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic             flush,
  input  logic             mem_reg_write,
  input  logic             mem_mem_to_reg,
  input  logic [4:0]       mem_rd,
  input  logic [2:0]       mem_funct3,
  input  logic [31:0]      mem_alu_result,
  input  logic [31:0]      mem_load_word,
  input  logic             mem_ecall,
  input  logic [31:0]      mem_pc,
  input  logic             halt_in,
  output logic             wb_en,
  output logic [4:0]       wb_rd_index,
  output logic [31:0]      wb_data,
  output logic             wb_ecall_sig,
  output logic [31:0]      wb_pc,
  output logic             load_misalign,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             halted
);

  wb_state_t        state_q, state_d;
  logic             wb_en_q, wb_en_d;
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      data_q, data_d;
  logic             ecall_q, ecall_d;
  logic [31:0]      pc_q, pc_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] load_data;
  logic        load_mis;
  logic        capture;

  load_align u_load_align (
    .word_i     (mem_load_word),
    .offset_i   (mem_alu_result[1:0]),
    .funct3_i   (mem_funct3),
    .data_o     (load_data),
    .misalign_o (load_mis)
  );

  // Only RUN accepts, so flush is naturally ignored while stalled.
  assign mem_ready = (state_q == RUN);
  assign capture   = mem_valid & mem_ready & ~flush;

  always_comb begin
    state_d    = state_q;
    wb_en_d    = 1'b0;
    ecall_d    = 1'b0;
    misalign_d = 1'b0;
    rd_d       = rd_q;
    data_d     = data_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;

    case (state_q)
      RUN: begin
        if (capture) begin
          rd_d       = mem_rd;
          pc_d       = mem_pc;
          data_d     = mem_mem_to_reg ? load_data : mem_alu_result;
          misalign_d = mem_mem_to_reg & load_mis;
          wb_en_d    = mem_reg_write & (mem_rd != 5'd0) & ~mem_ecall
                       & ~(mem_mem_to_reg & load_mis);
          ecall_d    = mem_ecall;
          cnt_d      = cnt_q + CNT_W'(1);
          if (mem_ecall) state_d = ECALL_WAIT;
        end
      end
      ECALL_WAIT: state_d = halt_in ? HALTED : RUN;
      HALTED:     state_d = HALTED;
      default:    state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wb_en_q    <= 1'b0;
      rd_q       <= 5'd0;
      data_q     <= 32'h0;
      ecall_q    <= 1'b0;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      wb_en_q    <= wb_en_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
      ecall_q    <= ecall_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  assign wb_en         = wb_en_q;
  assign wb_rd_index   = rd_q;
  assign wb_data       = data_q;
  assign wb_ecall_sig  = ecall_q;
  assign wb_pc         = pc_q;
  assign load_misalign = misalign_q;
  assign retired_cnt   = cnt_q;
  assign halted        = (state_q == HALTED);

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage: loads, misalignment, flush, ecall/halt
// sequencing, reset priority and counter wrap, with hand-computed expectations.
module tb_wb_stage;

  localparam int          CNT_W    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic             clk = 1'b0;
  logic             rst;
  logic             mem_valid, mem_ready, flush;
  logic             mem_reg_write, mem_mem_to_reg, mem_ecall, halt_in;
  logic [4:0]       mem_rd;
  logic [2:0]       mem_funct3;
  logic [31:0]      mem_alu_result, mem_load_word, mem_pc;
  logic             wb_en, wb_ecall_sig, load_misalign, halted;
  logic [4:0]       wb_rd_index;
  logic [31:0]      wb_data, wb_pc;
  logic [CNT_W-1:0] retired_cnt;

  int               checks = 0;
  int               failures = 0;
  logic [CNT_W-1:0] exp_cnt;

  wb_stage #(.CNT_W(CNT_W), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .flush          (flush),
    .mem_reg_write  (mem_reg_write),
    .mem_mem_to_reg (mem_mem_to_reg),
    .mem_rd         (mem_rd),
    .mem_funct3     (mem_funct3),
    .mem_alu_result (mem_alu_result),
    .mem_load_word  (mem_load_word),
    .mem_ecall      (mem_ecall),
    .mem_pc         (mem_pc),
    .halt_in        (halt_in),
    .wb_en          (wb_en),
    .wb_rd_index    (wb_rd_index),
    .wb_data        (wb_data),
    .wb_ecall_sig   (wb_ecall_sig),
    .wb_pc          (wb_pc),
    .load_misalign  (load_misalign),
    .retired_cnt    (retired_cnt),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_valid = 1'b0; flush = 1'b0; mem_reg_write = 1'b0; mem_mem_to_reg = 1'b0;
    mem_ecall = 1'b0; mem_rd = 5'd0; mem_funct3 = 3'b000;
    mem_alu_result = 32'h0; mem_load_word = 32'h0; mem_pc = 32'h0;
  endtask

  task automatic offer_alu(input logic [4:0] rd, input logic [31:0] res, input logic [31:0] pc);
    idle();
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = rd; mem_alu_result = res; mem_pc = pc;
  endtask

  task automatic offer_load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] word, input logic [31:0] pc);
    idle();
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_mem_to_reg = 1'b1; mem_rd = rd;
    mem_funct3 = f3; mem_alu_result = addr; mem_load_word = word; mem_pc = pc;
  endtask

  task automatic offer_ecall(input logic [31:0] pc);
    idle();
    mem_valid = 1'b1; mem_ecall = 1'b1; mem_pc = pc;
  endtask

  task automatic test_reset();
    checks++; if (wb_en !== 1'b0) begin failures++; $display("FAIL reset_wb_en: got %b want 0", wb_en); end
    checks++; if (wb_data !== 32'h0) begin failures++; $display("FAIL reset_wb_data: got %h want 0", wb_data); end
    checks++; if (wb_rd_index !== 5'd0) begin failures++; $display("FAIL reset_rd: got %0d want 0", wb_rd_index); end
    checks++; if (wb_pc !== RESET_PC) begin failures++; $display("FAIL reset_pc: got %h want %h", wb_pc, RESET_PC); end
    checks++; if (retired_cnt !== '0) begin failures++; $display("FAIL reset_cnt: got %0d want 0", retired_cnt); end
    checks++; if ({wb_ecall_sig, load_misalign, halted} !== 3'b000) begin
      failures++; $display("FAIL reset_flags: got %b want 000", {wb_ecall_sig, load_misalign, halted});
    end
    checks++; if (mem_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", mem_ready); end
  endtask

  task automatic test_load_byte();
    offer_load(5'd3, 3'b000, 32'h0000_0101, 32'h1234_80FF, 32'h0000_1000);
    step(); exp_cnt++;
    idle();
    checks++; if (wb_data !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_data: got %h want ffffff80", wb_data); end
    checks++; if (wb_en !== 1'b1) begin failures++; $display("FAIL lb_en: got %b want 1", wb_en); end
    checks++; if (wb_rd_index !== 5'd3) begin failures++; $display("FAIL lb_rd: got %0d want 3", wb_rd_index); end
    checks++; if (wb_pc !== 32'h0000_1000) begin failures++; $display("FAIL lb_pc: got %h want 00001000", wb_pc); end
    checks++; if (retired_cnt !== exp_cnt) begin failures++; $display("FAIL lb_cnt: got %0d want %0d", retired_cnt, exp_cnt); end
    offer_load(5'd11, 3'b100, 32'h0000_0103, 32'h9A34_80FF, 32'h0000_1002);
    step(); exp_cnt++;
    checks++; if (wb_data !== 32'h0000_009A) begin failures++; $display("FAIL lbu_data: got %h want 0000009a", wb_data); end
  endtask

  task automatic test_load_half();
    offer_load(5'd4, 3'b101, 32'h0000_0102, 32'hABCD_1234, 32'h0000_1004);
    step(); exp_cnt++;
    checks++; if (wb_data !== 32'h0000_ABCD) begin failures++; $display("FAIL lhu_data: got %h want 0000abcd", wb_data); end
    checks++; if (wb_en !== 1'b1 || load_misalign !== 1'b0) begin
      failures++; $display("FAIL lhu_en: got en=%b mis=%b want en=1 mis=0", wb_en, load_misalign);
    end
    offer_load(5'd5, 3'b001, 32'h0000_0100, 32'h0000_8001, 32'h0000_1008);
    step(); exp_cnt++;
    checks++; if (wb_data !== 32'hFFFF_8001) begin failures++; $display("FAIL lh_data: got %h want ffff8001", wb_data); end
    checks++; if (retired_cnt !== exp_cnt) begin failures++; $display("FAIL lh_cnt: got %0d want %0d", retired_cnt, exp_cnt); end
  endtask

  task automatic test_misalign();
    offer_load(5'd6, 3'b010, 32'h0000_0102, 32'hDEAD_BEEF, 32'h0000_100C);
    step(); exp_cnt++;
    idle();
    checks++; if (load_misalign !== 1'b1) begin failures++; $display("FAIL lw_mis_flag: got %b want 1", load_misalign); end
    checks++; if (wb_en !== 1'b0) begin failures++; $display("FAIL lw_mis_en: got %b want 0", wb_en); end
    checks++; if (wb_data !== 32'h0) begin failures++; $display("FAIL lw_mis_data: got %h want 0", wb_data); end
    checks++; if (retired_cnt !== exp_cnt) begin failures++; $display("FAIL lw_mis_cnt: got %0d want %0d", retired_cnt, exp_cnt); end
    step();
    checks++; if (load_misalign !== 1'b0) begin failures++; $display("FAIL mis_pulse: got %b want 0", load_misalign); end
    offer_load(5'd7, 3'b101, 32'h0000_0101, 32'hABCD_1234, 32'h0000_1010);
    step(); exp_cnt++;
    checks++; if ({load_misalign, wb_en} !== 2'b10) begin
      failures++; $display("FAIL lhu_mis: got mis,en=%b want 10", {load_misalign, wb_en});
    end
  endtask

  task automatic test_rd_zero();
    offer_alu(5'd0, 32'h0000_0055, 32'h0000_1014);
    step(); exp_cnt++;
    checks++; if (wb_en !== 1'b0) begin failures++; $display("FAIL rd0_en: got %b want 0", wb_en); end
    checks++; if (wb_data !== 32'h0000_0055) begin failures++; $display("FAIL rd0_data: got %h want 00000055", wb_data); end
    checks++; if (retired_cnt !== exp_cnt) begin failures++; $display("FAIL rd0_cnt: got %0d want %0d", retired_cnt, exp_cnt); end
  endtask

  task automatic test_flush();
    offer_alu(5'd5, 32'h0000_0077, 32'h0000_2000);
    flush = 1'b1;
    step();
    idle();
    checks++; if (wb_en !== 1'b0) begin failures++; $display("FAIL flush_en: got %b want 0", wb_en); end
    checks++; if (retired_cnt !== exp_cnt) begin failures++; $display("FAIL flush_cnt: got %0d want %0d", retired_cnt, exp_cnt); end
    checks++; if ({wb_rd_index, wb_data, wb_pc} !== {5'd0, 32'h0000_0055, 32'h0000_1014}) begin
      failures++; $display("FAIL flush_hold: got rd=%0d data=%h pc=%h want rd=0 data=00000055 pc=00001014",
                           wb_rd_index, wb_data, wb_pc);
    end
  endtask

  task automatic test_back_to_back();
    offer_alu(5'd7, 32'h0000_0011, 32'h0000_3000);
    step(); exp_cnt++;
    checks++; if ({wb_en, wb_rd_index, wb_data} !== {1'b1, 5'd7, 32'h0000_0011}) begin
      failures++; $display("FAIL b2b_first: got en=%b rd=%0d data=%h want en=1 rd=7 data=00000011", wb_en, wb_rd_index, wb_data);
    end
    offer_alu(5'd8, 32'h0000_0022, 32'h0000_3004);
    step(); exp_cnt++;
    checks++; if ({wb_en, wb_rd_index, wb_data} !== {1'b1, 5'd8, 32'h0000_0022}) begin
      failures++; $display("FAIL b2b_second: got en=%b rd=%0d data=%h want en=1 rd=8 data=00000022", wb_en, wb_rd_index, wb_data);
    end
    offer_load(5'd9, 3'b010, 32'h0000_0100, 32'hCAFE_F00D, 32'h0000_3008);
    step(); exp_cnt++;
    idle();
    checks++; if ({wb_en, wb_data} !== {1'b1, 32'hCAFE_F00D}) begin
      failures++; $display("FAIL b2b_lw: got en=%b data=%h want en=1 data=cafef00d", wb_en, wb_data);
    end
    checks++; if (retired_cnt !== exp_cnt) begin failures++; $display("FAIL b2b_cnt: got %0d want %0d", retired_cnt, exp_cnt); end
  endtask

  task automatic test_ecall_resume();
    offer_ecall(32'h0000_4000);
    halt_in = 1'b0;
    step(); exp_cnt++;
    // Offer a real instruction (with flush) during the stall; it must not be taken.
    offer_alu(5'd10, 32'h0000_0033, 32'h0000_4004);
    flush = 1'b1;
    checks++; if ({wb_ecall_sig, wb_en, mem_ready} !== 3'b100) begin
      failures++; $display("FAIL ecall_r_sig: got sig,en,ready=%b want 100", {wb_ecall_sig, wb_en, mem_ready});
    end
    checks++; if (retired_cnt !== exp_cnt) begin failures++; $display("FAIL ecall_r_cnt: got %0d want %0d", retired_cnt, exp_cnt); end
    step();
    flush = 1'b0;
    checks++; if ({wb_ecall_sig, wb_en, mem_ready, halted} !== 4'b0010) begin
      failures++; $display("FAIL ecall_r_back: got sig,en,ready,halted=%b want 0010", {wb_ecall_sig, wb_en, mem_ready, halted});
    end
    checks++; if (retired_cnt !== exp_cnt) begin failures++; $display("FAIL ecall_r_stall_cnt: got %0d want %0d", retired_cnt, exp_cnt); end
    step(); exp_cnt++;
    idle();
    checks++; if ({wb_en, wb_rd_index, wb_data} !== {1'b1, 5'd10, 32'h0000_0033}) begin
      failures++; $display("FAIL ecall_r_next: got en=%b rd=%0d data=%h want en=1 rd=10 data=00000033", wb_en, wb_rd_index, wb_data);
    end
  endtask

  task automatic test_ecall_halt();
    offer_ecall(32'h0000_5000);
    halt_in = 1'b1;
    step(); exp_cnt++;
    offer_alu(5'd12, 32'h0000_0044, 32'h0000_5004);
    checks++; if ({wb_ecall_sig, wb_en, mem_ready, halted} !== 4'b1000) begin
      failures++; $display("FAIL ecall_h_sig: got sig,en,ready,halted=%b want 1000", {wb_ecall_sig, wb_en, mem_ready, halted});
    end
    checks++; if (wb_pc !== 32'h0000_5000) begin failures++; $display("FAIL ecall_h_pc: got %h want 00005000", wb_pc); end
    step();
    halt_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({wb_ecall_sig, wb_en, mem_ready, halted} !== 4'b0001) begin
        failures++; $display("FAIL halted_%0d: got sig,en,ready,halted=%b want 0001", i, {wb_ecall_sig, wb_en, mem_ready, halted});
      end
      step();
    end
    checks++; if (retired_cnt !== exp_cnt) begin failures++; $display("FAIL halted_cnt: got %0d want %0d", retired_cnt, exp_cnt); end
  endtask

  task automatic test_reset_halted();
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    exp_cnt = '0;
    checks++; if ({halted, mem_ready, wb_en, wb_ecall_sig} !== 4'b0100) begin
      failures++; $display("FAIL rst_halt_state: got halted,ready,en,sig=%b want 0100", {halted, mem_ready, wb_en, wb_ecall_sig});
    end
    checks++; if ({wb_data, wb_pc, retired_cnt} !== {32'h0, RESET_PC, 4'h0}) begin
      failures++; $display("FAIL rst_halt_outs: got data=%h pc=%h cnt=%0d want data=0 pc=%h cnt=0", wb_data, wb_pc, retired_cnt, RESET_PC);
    end
  endtask

  task automatic test_reset_ecall_wait();
    offer_ecall(32'h0000_6000);
    halt_in = 1'b1;
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    halt_in = 1'b0;
    checks++; if ({halted, mem_ready, wb_ecall_sig, wb_en} !== 4'b0100) begin
      failures++; $display("FAIL rst_wait_state: got halted,ready,sig,en=%b want 0100", {halted, mem_ready, wb_ecall_sig, wb_en});
    end
    checks++; if ({wb_pc, retired_cnt} !== {RESET_PC, 4'h0}) begin
      failures++; $display("FAIL rst_wait_outs: got pc=%h cnt=%0d want pc=%h cnt=0", wb_pc, retired_cnt, RESET_PC);
    end
    step();
    checks++; if ({halted, mem_ready} !== 2'b01) begin
      failures++; $display("FAIL rst_wait_after: got halted,ready=%b want 01", {halted, mem_ready});
    end
  endtask

  task automatic test_cnt_wrap();
    for (int i = 0; i < 16; i++) begin
      offer_alu(5'd1, i, 32'h0000_7000 + 32'(i) * 4);
      step(); exp_cnt++;
      if (i == 14) begin
        checks++; if (retired_cnt !== 4'hF) begin failures++; $display("FAIL cnt_max: got %0d want 15", retired_cnt); end
      end
    end
    idle();
    checks++; if (retired_cnt !== 4'h0) begin failures++; $display("FAIL cnt_wrap: got %0d want 0", retired_cnt); end
    checks++; if (retired_cnt !== exp_cnt) begin failures++; $display("FAIL cnt_track: got %0d want %0d", retired_cnt, exp_cnt); end
  endtask

  initial begin
    idle();
    halt_in = 1'b0;
    rst = 1'b1;
    exp_cnt = '0;
    step();
    step();
    rst = 1'b0;
    test_reset();
    step();
    test_reset();
    test_load_byte();
    test_load_half();
    test_misalign();
    test_rd_zero();
    test_flush();
    test_back_to_back();
    test_ecall_resume();
    test_ecall_halt();
    test_reset_halted();
    test_reset_ecall_wait();
    test_cnt_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
